heater_tx_scheduler: RTL and testbench

//  Sequences the ro_heating_enable input of the 16x heater_1024 RO heater array, which
//  is the transmitter of the temporal thermal covert channel.

---
 rtl/heater_tx_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_heater_tx_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/heater_tx_scheduler.sv
// heater_tx_scheduler: sequences the RO heater enable to transmit one message
// word MSB-first over the thermal covert channel. Each symbol is a HEAT phase
// (heater follows the bit) followed by a COOL phase (heater off).
// Optional feature macro: HEATER_PREAMBLE_EN -- prepends the 8-bit sync
// pattern 1011_0010 (MSB first) before the payload, using the same timing.
module heater_tx_scheduler #(
    parameter int MSG_W = 64,
    parameter int CNT_W = 32,
    parameter int LEN_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             msg_valid,
    output logic             msg_ready,
    input  logic [MSG_W-1:0] msg_data,
    input  logic [LEN_W-1:0] msg_len,
    input  logic [CNT_W-1:0] heat_period,
    input  logic [CNT_W-1:0] cool_period,
    input  logic             abort,
    output logic             heat_en,
    output logic             busy,
    output logic [LEN_W-1:0] bit_idx,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] heat_cycles
);

`ifdef HEATER_PREAMBLE_EN
    typedef enum logic [2:0] {IDLE, PRE_HEAT, PRE_COOL, HEAT, COOL, DONE} state_t;
    localparam logic [7:0] SYNC_PAT = 8'b1011_0010;
    logic [7:0] pre_sreg;
    logic [2:0] pre_cnt;
`else
    typedef enum logic [2:0] {IDLE, HEAT, COOL, DONE} state_t;
`endif

    state_t           state;
    logic [MSG_W-1:0] sreg;     // payload, left-aligned; current bit is the MSB
    logic [CNT_W-1:0] timer;    // cycles remaining in the current phase, minus one
    logic [CNT_W-1:0] hp_m1;
    logic [CNT_W-1:0] cp_m1;

    logic [LEN_W-1:0] len_clamp;
    logic [MSG_W-1:0] data_aligned;
    logic [CNT_W-1:0] hp_in_m1;
    logic [CNT_W-1:0] cp_in_m1;
    logic             accept;

    // Input conditioning at accept: clamp length, left-align payload, map 0-length phases to 1
    always_comb begin
        len_clamp    = msg_len;
        if (msg_len > LEN_W'(MSG_W))
            len_clamp = LEN_W'(MSG_W);
        data_aligned = msg_data << (LEN_W'(MSG_W) - len_clamp);
        hp_in_m1     = (heat_period == '0) ? '0 : heat_period - CNT_W'(1);
        cp_in_m1     = (cool_period == '0) ? '0 : cool_period - CNT_W'(1);
        accept       = msg_valid & msg_ready;
    end

    // Main sequencer; every output is a flop so heat_en cannot glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sreg        <= '0;
            timer       <= '0;
            hp_m1       <= '0;
            cp_m1       <= '0;
            msg_ready   <= 1'b1;
            heat_en     <= 1'b0;
            busy        <= 1'b0;
            bit_idx     <= '0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            heat_cycles <= '0;
`ifdef HEATER_PREAMBLE_EN
            pre_sreg    <= '0;
            pre_cnt     <= '0;
`endif
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            if (heat_en && heat_cycles != '1)
                heat_cycles <= heat_cycles + CNT_W'(1);

            if (state != IDLE && abort) begin
                state     <= IDLE;
                heat_en   <= 1'b0;
                aborted   <= 1'b1;
                msg_ready <= 1'b1;
                busy      <= 1'b0;
                bit_idx   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            sreg        <= data_aligned;
                            hp_m1       <= hp_in_m1;
                            cp_m1       <= cp_in_m1;
                            timer       <= hp_in_m1;
                            bit_idx     <= len_clamp;
                            heat_cycles <= '0;
                            msg_ready   <= 1'b0;
                            busy        <= 1'b1;
`ifdef HEATER_PREAMBLE_EN
                            state    <= PRE_HEAT;
                            heat_en  <= SYNC_PAT[7];
                            pre_sreg <= SYNC_PAT << 1;
                            pre_cnt  <= 3'd7;
`else
                            if (len_clamp == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state   <= HEAT;
                                heat_en <= data_aligned[MSG_W-1];
                            end
`endif
                        end
                    end
`ifdef HEATER_PREAMBLE_EN
                    PRE_HEAT: begin
                        if (timer == '0) begin
                            state   <= PRE_COOL;
                            heat_en <= 1'b0;
                            timer   <= cp_m1;
                        end else begin
                            timer <= timer - CNT_W'(1);
                        end
                    end
                    PRE_COOL: begin
                        if (timer != '0) begin
                            timer <= timer - CNT_W'(1);
                        end else if (pre_cnt != '0) begin
                            state    <= PRE_HEAT;
                            heat_en  <= pre_sreg[7];
                            pre_sreg <= pre_sreg << 1;
                            pre_cnt  <= pre_cnt - 3'd1;
                            timer    <= hp_m1;
                        end else if (bit_idx != '0) begin
                            state   <= HEAT;
                            heat_en <= sreg[MSG_W-1];
                            timer   <= hp_m1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
`endif
                    HEAT: begin
                        if (timer == '0) begin
                            state   <= COOL;
                            heat_en <= 1'b0;
                            timer   <= cp_m1;
                        end else begin
                            timer <= timer - CNT_W'(1);
                        end
                    end
                    COOL: begin
                        if (timer != '0) begin
                            timer <= timer - CNT_W'(1);
                        end else begin
                            bit_idx <= bit_idx - LEN_W'(1);
                            if (bit_idx != LEN_W'(1)) begin
                                state   <= HEAT;
                                heat_en <= sreg[MSG_W-2];
                                sreg    <= sreg << 1;
                                timer   <= hp_m1;
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state     <= IDLE;
                        msg_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                    default: begin
                        state     <= IDLE;
                        heat_en   <= 1'b0;
                        msg_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_heater_tx_scheduler.sv
// Directed self-checking bench for heater_tx_scheduler (default parameters).
module tb_heater_tx_scheduler;

`ifdef HEATER_PREAMBLE_EN
    localparam int PRE_SYM = 8;
`else
    localparam int PRE_SYM = 0;
`endif
    localparam logic [7:0] PRE_PAT = 8'b1011_0010;

    logic        clk = 1'b0;
    logic        rst;
    logic        msg_valid;
    logic        msg_ready;
    logic [63:0] msg_data;
    logic [6:0]  msg_len;
    logic [31:0] heat_period;
    logic [31:0] cool_period;
    logic        abort;
    logic        heat_en;
    logic        busy;
    logic [6:0]  bit_idx;
    logic        done;
    logic        aborted;
    logic [31:0] heat_cycles;

    int total = 0;
    int bad   = 0;

    heater_tx_scheduler #(.MSG_W(64), .CNT_W(32), .LEN_W(7)) dut (
        .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .msg_data(msg_data), .msg_len(msg_len), .heat_period(heat_period),
        .cool_period(cool_period), .abort(abort), .heat_en(heat_en), .busy(busy),
        .bit_idx(bit_idx), .done(done), .aborted(aborted), .heat_cycles(heat_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected heat_en n cycles after the accept edge (n >= 1)
    function automatic logic exp_heat(input logic [63:0] data, input int len, input int h,
                                      input int c, input int n);
        int s;
        int ph;
        s  = (n - 1) / (h + c);
        ph = (n - 1) % (h + c);
        if (ph >= h) return 1'b0;
        if (s < PRE_SYM) return PRE_PAT[7 - s];
        return data[len - 1 - (s - PRE_SYM)];
    endfunction

    task automatic offer(input logic [63:0] data, input int len, input int hp, input int cp);
        msg_data    = data;
        msg_len     = 7'(len);
        heat_period = 32'(hp);
        cool_period = 32'(cp);
        msg_valid   = 1'b1;
        tick();
        msg_valid   = 1'b0;
    endtask

    // Sends one message and checks every cycle up to and just after done
    task automatic run_msg(input string tag, input logic [63:0] data, input int len,
                           input int hp, input int cp);
        int l;
        int h;
        int c;
        int last;
        int hc;
        int s;
        int eidx;
        l    = (len > 64) ? 64 : len;
        h    = (hp == 0) ? 1 : hp;
        c    = (cp == 0) ? 1 : cp;
        last = (l + PRE_SYM) * (h + c) + 1;
        hc   = 0;
        offer(data, len, hp, cp);
        chk({tag, " ready_low"}, 64'(msg_ready), 64'd0);
        for (int n = 1; n <= last; n++) begin
            s    = (n - 1) / (h + c);
            eidx = (n == last) ? 0 : ((s < PRE_SYM) ? l : l - (s - PRE_SYM));
            chk($sformatf("%s busy@%0d", tag, n), 64'(busy), 64'd1);
            chk($sformatf("%s done@%0d", tag, n), 64'(done), 64'(n == last));
            chk($sformatf("%s bit_idx@%0d", tag, n), 64'(bit_idx), 64'(eidx));
            if (n == last) begin
                chk($sformatf("%s heat@%0d", tag, n), 64'(heat_en), 64'd0);
                chk({tag, " heat_cycles"}, 64'(heat_cycles), 64'(hc));
            end else begin
                chk($sformatf("%s heat@%0d", tag, n), 64'(heat_en),
                    64'(exp_heat(data, l, h, c, n)));
                if (exp_heat(data, l, h, c, n)) hc++;
                tick();
            end
        end
        tick();
        chk({tag, " ready_after"}, 64'(msg_ready), 64'd1);
        chk({tag, " busy_after"}, 64'(busy), 64'd0);
        chk({tag, " done_after"}, 64'(done), 64'd0);
    endtask

    initial begin
        int t0;
        int done_seen;
        rst         = 1'b1;
        msg_valid   = 1'b0;
        msg_data    = '0;
        msg_len     = '0;
        heat_period = '0;
        cool_period = '0;
        abort       = 1'b0;

        // Reset held for 3 cycles
        repeat (3) tick();
        chk("rst ready", 64'(msg_ready), 64'd1);
        chk("rst heat", 64'(heat_en), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst aborted", 64'(aborted), 64'd0);
        chk("rst heat_cycles", 64'(heat_cycles), 64'd0);
        rst = 1'b0;
        tick();

        // Basic message: A5, len 8, 4/2 -> done at T+49 (no preamble), 16 heat cycles
        run_msg("basic", 64'hA5, 8, 4, 2);
        chk("basic hc_const", 64'(heat_cycles), 64'(16 + (PRE_SYM != 0 ? 16 : 0)));

        // Zero length and zero periods
        run_msg("len0", 64'h0, 0, 3, 2);
        run_msg("zero_per", 64'h1, 1, 0, 0);

        // Abort during the 2nd HEAT cycle of bit 3 of 8
        offer(64'hFF, 8, 4, 2);
        repeat ((PRE_SYM + 2) * 6 + 1) tick();
        chk("abort heat_before", 64'(heat_en), 64'd1);
        chk("abort idx_before", 64'(bit_idx), 64'd6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort heat", 64'(heat_en), 64'd0);
        chk("abort pulse", 64'(aborted), 64'd1);
        chk("abort ready", 64'(msg_ready), 64'd1);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (done) done_seen++;
        end
        chk("abort aborted_clear", 64'(aborted), 64'd0);
        chk("abort no_done", 64'(done_seen), 64'd0);

        // Abort in IDLE is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort pulse", 64'(aborted), 64'd0);
        chk("idle_abort ready", 64'(msg_ready), 64'd1);

        // Back-pressure: valid held, heat_period changed mid-message
        msg_data    = 64'h2;
        msg_len     = 7'd2;
        heat_period = 32'd3;
        cool_period = 32'd1;
        msg_valid   = 1'b1;
        tick();
        t0 = (PRE_SYM + 2) * 4 + 1;
        for (int n = 1; n <= t0; n++) begin
            if (n == 2) heat_period = 32'd10;
            chk($sformatf("bp ready@%0d", n), 64'(msg_ready), 64'd0);
            chk($sformatf("bp done@%0d", n), 64'(done), 64'(n == t0));
            if (n < t0) tick();
        end
        tick();
        chk("bp ready_gap", 64'(msg_ready), 64'd1);
        chk("bp busy_gap", 64'(busy), 64'd0);
        tick();
        msg_valid = 1'b0;
        chk("bp second_busy", 64'(busy), 64'd1);
        chk("bp second_heat", 64'(heat_en), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("bp second_abort", 64'(aborted), 64'd1);
        tick();

        // Clamp: len 100 -> 64 symbols
        run_msg("clamp", 64'hF0F0_1234_8001_FFFF, 100, 1, 1);

        // Single-bit message (covers the full preamble when enabled)
        run_msg("one_bit", 64'h1, 1, 1, 1);

        // Asynchronous reset mid-HEAT drops heat_en immediately
        offer(64'h1, 1, 5, 1);
        chk("areset heat_before", 64'(heat_en), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("areset heat", 64'(heat_en), 64'd0);
        chk("areset done", 64'(done), 64'd0);
        chk("areset aborted", 64'(aborted), 64'd0);
        chk("areset ready", 64'(msg_ready), 64'd1);
        tick();
        rst = 1'b0;
        tick();
        chk("areset idle_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
